// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART-side ALU host interface.
// Holds the opcode encodings (used by the RTL and the bench) and a sizing helper.
package uart_alu_interface_pkg;

  localparam int OP_WIDTH = 6;

  localparam logic [OP_WIDTH-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_WIDTH-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_WIDTH-1:0] OP_AND = 6'b100100;
  localparam logic [OP_WIDTH-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_WIDTH-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_WIDTH-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_WIDTH-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_WIDTH-1:0] OP_SRL = 6'b000010;

  // Width of the inter-byte timeout counter. It must hold TIMEOUT_CYCLES itself,
  // and it keeps at least one bit when the timeout is disabled.
  function automatic int timeout_cnt_width(input int timeout_cycles);
    int w;
    if (timeout_cycles > 0) begin
      w = $clog2(timeout_cycles + 1);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_alu_interface_alu.sv
// Purely combinational ALU used by the UART host interface.
// Shifts use the whole B operand as the shift amount, so large shifts give
// sign-fill (SRA) or zero (SRL). Unknown opcodes return zero.
module alu
  import uart_alu_interface_pkg::*;
#(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6
) (
  input  logic [SIZEDATA-1:0] i_data_a,
  input  logic [SIZEDATA-1:0] i_data_b,
  input  logic [SIZEOP-1:0]   i_op,
  output logic [SIZEDATA-1:0] o_result
);

  // Decode the opcode and select the matching datapath result
  always_comb begin
    o_result = {SIZEDATA{1'b0}};
    case (i_op)
      SIZEOP'(OP_ADD): o_result = i_data_a + i_data_b;
      SIZEOP'(OP_SUB): o_result = i_data_a - i_data_b;
      SIZEOP'(OP_AND): o_result = i_data_a & i_data_b;
      SIZEOP'(OP_OR):  o_result = i_data_a | i_data_b;
      SIZEOP'(OP_XOR): o_result = i_data_a ^ i_data_b;
      SIZEOP'(OP_NOR): o_result = ~(i_data_a | i_data_b);
      SIZEOP'(OP_SRA): o_result = $signed(i_data_a) >>> i_data_b;
      SIZEOP'(OP_SRL): o_result = i_data_a >> i_data_b;
      default:         o_result = {SIZEDATA{1'b0}};
    endcase
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Host-side UART <-> ALU bridge.
// Collects operand A, operand B and an opcode byte from the UART receiver,
// computes the result and hands one byte to the UART transmitter.
// An optional inter-byte timeout aborts partial frames; bytes arriving while
// a result is in flight are dropped and flagged.
module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int SIZEDATA       = 8,
  parameter int SIZEOP         = 6,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done,
  input  logic [SIZEDATA-1:0] i_rx_data,
  input  logic                i_tx_done,
  output logic                o_tx_signal,
  output logic [SIZEDATA-1:0] o_tx_result,
  output logic                o_busy,
  output logic                o_timeout,
  output logic                o_overrun
);

  localparam int CNTW   = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam int TERM_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNTW-1:0] TERM = TERM_I[CNTW-1:0];
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_COMPUTE = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [SIZEDATA-1:0] r_data_a;
  logic [SIZEDATA-1:0] r_data_b;
  logic [SIZEOP-1:0]   r_op;
  logic [SIZEDATA-1:0] r_tx_result;
  logic [CNTW-1:0]     r_cnt;
  logic                r_tx_signal;
  logic                r_busy;
  logic                r_timeout;
  logic                r_overrun;

  logic [SIZEDATA-1:0] w_alu_result;
  logic                w_cap_a;
  logic                w_cap_b;
  logic                w_cap_op;
  logic                w_expire;
  logic                w_overrun;
  logic                w_cnt_at_term;

  // The terminal count only matters when the timeout is enabled
  assign w_cnt_at_term = TO_EN && (r_cnt == TERM);

  alu #(
    .SIZEDATA (SIZEDATA),
    .SIZEOP   (SIZEOP)
  ) u_alu (
    .i_data_a (r_data_a),
    .i_data_b (r_data_b),
    .i_op     (r_op),
    .o_result (w_alu_result)
  );

  // Next-state logic plus the capture/abort/drop strobes derived from it
  always_comb begin
    w_next_state = r_state;
    w_cap_a      = 1'b0;
    w_cap_b      = 1'b0;
    w_cap_op     = 1'b0;
    w_expire     = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      S_WAIT_A: begin
        if (i_rx_done) begin
          w_cap_a      = 1'b1;
          w_next_state = S_WAIT_B;
        end else begin
          w_next_state = S_WAIT_A;
        end
      end
      S_WAIT_B: begin
        // A byte in the terminal cycle wins over the timeout
        if (i_rx_done) begin
          w_cap_b      = 1'b1;
          w_next_state = S_WAIT_OP;
        end else if (w_cnt_at_term) begin
          w_expire     = 1'b1;
          w_next_state = S_WAIT_A;
        end else begin
          w_next_state = S_WAIT_B;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_done) begin
          w_cap_op     = 1'b1;
          w_next_state = S_COMPUTE;
        end else if (w_cnt_at_term) begin
          w_expire     = 1'b1;
          w_next_state = S_WAIT_A;
        end else begin
          w_next_state = S_WAIT_OP;
        end
      end
      S_COMPUTE: begin
        w_overrun    = i_rx_done;
        w_next_state = S_SEND;
      end
      S_SEND: begin
        w_overrun    = i_rx_done;
        w_next_state = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        w_overrun = i_rx_done;
        if (i_tx_done) begin
          w_next_state = S_WAIT_A;
        end else begin
          w_next_state = S_WAIT_TX;
        end
      end
      default: begin
        w_next_state = S_WAIT_A;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_WAIT_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand/opcode capture; dropped bytes never reach these registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_data_a <= {SIZEDATA{1'b0}};
      r_data_b <= {SIZEDATA{1'b0}};
      r_op     <= {SIZEOP{1'b0}};
    end else begin
      if (w_cap_a) begin
        r_data_a <= i_rx_data;
      end
      if (w_cap_b) begin
        r_data_b <= i_rx_data;
      end
      if (w_cap_op) begin
        r_op <= i_rx_data[SIZEOP-1:0];
      end
    end
  end

  // Result register: loaded once per frame and held through the TX handshake
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_result <= {SIZEDATA{1'b0}};
    end else if (r_state == S_COMPUTE) begin
      r_tx_result <= w_alu_result;
    end
  end

  // Inter-byte timeout counter: clears on accepted bytes and when idle, saturates
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= {CNTW{1'b0}};
    end else if ((r_state == S_WAIT_A) || w_cap_a || w_cap_b || w_cap_op || w_expire) begin
      r_cnt <= {CNTW{1'b0}};
    end else if (TO_EN && ((r_state == S_WAIT_B) || (r_state == S_WAIT_OP))
                 && (r_cnt != {CNTW{1'b1}})) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  // Registered status outputs, decoded from the state being entered
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_signal <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_tx_signal <= (w_next_state == S_SEND);
      r_busy      <= (w_next_state == S_COMPUTE) || (w_next_state == S_SEND)
                     || (w_next_state == S_WAIT_TX);
      r_timeout   <= w_expire;
      r_overrun   <= w_overrun;
    end
  end

  assign o_tx_signal = r_tx_signal;
  assign o_tx_result = r_tx_result;
  assign o_busy      = r_busy;
  assign o_timeout   = r_timeout;
  assign o_overrun   = r_overrun;

endmodule
